// File: rtl/round_pipe.sv
// Two-stage valid/ready rounding pipeline for the FP multiplier datapath.
// Stage 1 decides the rounding increment; stage 2 forms the result and flags.
module round_pipe #(
    parameter int unsigned SHIFTWIDTH = 48,
    parameter int unsigned WSIG       = 23,
    parameter int unsigned WEXP       = 8,
    parameter int unsigned WEXPSUM    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SHIFTWIDTH-1:0] shiftprod,
    input  logic [WEXPSUM-1:0]    shiftexp,
    input  logic                  shiftloss,
    input  logic                  sign,
    input  logic                  tiny,
    input  logic [2:0]            roundmode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WSIG-1:0]       roundprod,
    output logic [WEXP-1:0]       roundexp,
    output logic                  inexact,
    output logic                  overflow,
    output logic                  stilltiny,
    output logic                  denormround,
    input  logic                  flag_clr,
    output logic [2:0]            flags_sticky
);

    localparam int unsigned SW = SHIFTWIDTH;

    logic [WSIG-1:0]    msb;
    logic               lsb, guard, sticky, dsticky, up, rovf;
    logic [WSIG:0]      msb_inc;
    logic               en1, en2;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_up_q, s1_up_d;
    logic               s1_rovf_q, s1_rovf_d;
    logic               s1_inexact_q, s1_inexact_d;
    logic               s1_dcand_q, s1_dcand_d;
    logic [WSIG-1:0]    s1_msb_q, s1_msb_d;
    logic [WSIG-1:0]    s1_inc_q, s1_inc_d;
    logic [WEXPSUM-1:0] s1_exp_q, s1_exp_d;

    logic [WEXPSUM-1:0] tempexp;
    logic [WSIG-1:0]    rp_c;
    logic [WEXP-1:0]    re_c;
    logic               ovf_c;

    logic               s2_valid_q, s2_valid_d;
    logic [WSIG-1:0]    roundprod_q, roundprod_d;
    logic [WEXP-1:0]    roundexp_q, roundexp_d;
    logic               inexact_q, inexact_d;
    logic               overflow_q, overflow_d;
    logic               stilltiny_q, stilltiny_d;
    logic               denormround_q, denormround_d;
    logic [2:0]         flags_q, flags_d;

    // Stage-0 decode: field split and mode-dependent increment decision.
    always_comb begin
        msb     = shiftprod[SW-1 -: WSIG];
        lsb     = shiftprod[SW-WSIG];
        guard   = shiftprod[SW-WSIG-1];
        sticky  = (|shiftprod[SW-WSIG-2:0]) | shiftloss;
        dsticky = (|shiftprod[SW-WSIG-3:0]) | shiftloss;
        msb_inc = {1'b0, msb} + {{WSIG{1'b0}}, 1'b1};
        up      = 1'b0;
        case (roundmode)
            3'b001:  up = 1'b0;
            3'b010:  up = ~sign & (guard | sticky);
            3'b011:  up = sign & (guard | sticky);
            3'b100:  up = guard;
            default: up = guard & (lsb | sticky);
        endcase
        rovf = msb_inc[WSIG] & up;
    end

    always_comb begin
        tempexp = s1_exp_q + {{(WEXPSUM-1){1'b0}}, s1_rovf_q};
        ovf_c   = (&tempexp[WEXP-1:0]) | (|tempexp[WEXPSUM-1:WEXP]);
        re_c    = tempexp[WEXP-1:0];
        rp_c    = s1_up_q ? (s1_rovf_q ? '0 : s1_inc_q) : s1_msb_q;
    end

    assign en2      = ~s2_valid_q | out_ready;
    assign en1      = ~s1_valid_q | en2;
    assign in_ready = en1;

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_up_d       = s1_up_q;
        s1_rovf_d     = s1_rovf_q;
        s1_inexact_d  = s1_inexact_q;
        s1_dcand_d    = s1_dcand_q;
        s1_msb_d      = s1_msb_q;
        s1_inc_d      = s1_inc_q;
        s1_exp_d      = s1_exp_q;
        s2_valid_d    = s2_valid_q;
        roundprod_d   = roundprod_q;
        roundexp_d    = roundexp_q;
        inexact_d     = inexact_q;
        overflow_d    = overflow_q;
        stilltiny_d   = stilltiny_q;
        denormround_d = denormround_q;
        flags_d       = flags_q;

        if (en1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_up_d      = up;
                s1_rovf_d    = rovf;
                s1_inexact_d = up | guard | sticky;
                s1_dcand_d   = tiny & ~dsticky & guard;
                s1_msb_d     = msb;
                s1_inc_d     = msb_inc[WSIG-1:0];
                s1_exp_d     = shiftexp;
            end
        end

        if (en2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                roundprod_d   = rp_c;
                roundexp_d    = re_c;
                inexact_d     = s1_inexact_q;
                overflow_d    = ovf_c;
                stilltiny_d   = (re_c == '0);
                denormround_d = s1_dcand_q & s1_up_q;
            end
        end

        // An event on the clearing handshake survives the clear.
        if (s2_valid_q & out_ready) begin
            flags_d = (flag_clr ? 3'b000 : flags_q) |
                      {overflow_q, stilltiny_q & inexact_q, inexact_q};
        end else if (flag_clr) begin
            flags_d = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_up_q       <= 1'b0;
            s1_rovf_q     <= 1'b0;
            s1_inexact_q  <= 1'b0;
            s1_dcand_q    <= 1'b0;
            s1_msb_q      <= '0;
            s1_inc_q      <= '0;
            s1_exp_q      <= '0;
            s2_valid_q    <= 1'b0;
            roundprod_q   <= '0;
            roundexp_q    <= '0;
            inexact_q     <= 1'b0;
            overflow_q    <= 1'b0;
            stilltiny_q   <= 1'b0;
            denormround_q <= 1'b0;
            flags_q       <= 3'b000;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_up_q       <= s1_up_d;
            s1_rovf_q     <= s1_rovf_d;
            s1_inexact_q  <= s1_inexact_d;
            s1_dcand_q    <= s1_dcand_d;
            s1_msb_q      <= s1_msb_d;
            s1_inc_q      <= s1_inc_d;
            s1_exp_q      <= s1_exp_d;
            s2_valid_q    <= s2_valid_d;
            roundprod_q   <= roundprod_d;
            roundexp_q    <= roundexp_d;
            inexact_q     <= inexact_d;
            overflow_q    <= overflow_d;
            stilltiny_q   <= stilltiny_d;
            denormround_q <= denormround_d;
            flags_q       <= flags_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign roundprod    = roundprod_q;
    assign roundexp     = roundexp_q;
    assign inexact      = inexact_q;
    assign overflow     = overflow_q;
    assign stilltiny    = stilltiny_q;
    assign denormround  = denormround_q;
    assign flags_sticky = flags_q;

endmodule
